ctrl_pipe_unit: RTL

Parametrised control and flag unit for the pipelined LEGv8 core. It decodes the instruction in ID and resolves branches there, including every B.cond condition against an architectural NZCV register with EX-stage bypass. It carries the decoded control word down registered EX/MEM/WB stages and supports stall and flush. It replaces the flat combinational decoder plus LT-only branch logic.

---
 rtl/ctrl_pkg.sv | 47 ++++
 rtl/ctrl_pipe_unit_cond.sv | 43 ++++
 rtl/ctrl_pipe_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and opcode patterns for the LEGv8 control/flag unit.
// Opcode constants are the fixed-width prefixes of instr[31:*].
package ctrl_pkg;

    localparam int RD_W = 5;
    localparam logic [RD_W-1:0] XZR = 5'd31;

    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [5:0]  OP_BL    = 6'b100101;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
    localparam logic [10:0] OP_ADDS  = 11'b10101011000;
    localparam logic [10:0] OP_SUBS  = 11'b11101011000;
    localparam logic [10:0] OP_BR    = 11'b11010110000;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;

    typedef enum logic [2:0] {
        PASS = 3'b000,
        ADD  = 3'b010,
        SUB  = 3'b011
    } alu_op_e;

    typedef enum logic [3:0] {
        EQ = 4'h0, NE = 4'h1, HS = 4'h2, LO = 4'h3,
        MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
        HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
        GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
    } cond_e;

    typedef struct packed {
        alu_op_e         alu_op;
        logic            alu_src_imm;
        logic            set_flags;
        logic            mem_rd;
        logic            mem_wr;
        logic            reg_write;
        logic            mem_to_reg;
        logic [RD_W-1:0] rd;
    } ctrl_word_t;

    function automatic logic is_xzr(input logic [RD_W-1:0] rd);
        return rd == XZR;
    endfunction

endpackage

// File: rtl/ctrl_pipe_unit_cond.sv
// B.cond evaluator: condition code and NZCV to taken.
// With FULL_COND = 0 only LT can be taken.
module cond_eval
    import ctrl_pkg::*;
#(
    parameter bit FULL_COND = 1'b1
) (
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       taken
);

    logic n, z, c, v;
    logic full_taken;

    assign {n, z, c, v} = nzcv;

    always_comb begin
        full_taken = 1'b0;
        unique case (cond_e'(cond))
            EQ: full_taken = z;
            NE: full_taken = ~z;
            HS: full_taken = c;
            LO: full_taken = ~c;
            MI: full_taken = n;
            PL: full_taken = ~n;
            VS: full_taken = v;
            VC: full_taken = ~v;
            HI: full_taken = c & ~z;
            LS: full_taken = ~(c & ~z);
            GE: full_taken = (n == v);
            LT: full_taken = (n != v);
            GT: full_taken = ~z & (n == v);
            LE: full_taken = ~(~z & (n == v));
            AL: full_taken = 1'b1;
            NV: full_taken = 1'b1;
        endcase
    end

    assign taken = FULL_COND ? full_taken
                             : ((cond == LT) & (n != v));

endmodule

// File: rtl/ctrl_pipe_unit.sv
// ID decode and branch resolution with NZCV bypass, plus the
// registered EX/MEM/WB control pipeline and architectural flags.
module ctrl_pipe_unit
    import ctrl_pkg::*;
#(
    parameter bit FULL_COND = 1'b1,
    parameter int LINK_REG  = 30,
    parameter int REG_W     = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic             cbz_zero,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_c,
    input  logic             alu_v,
    output logic             br_taken,
    output logic             br_uncond,
    output logic             br_reg,
    output logic             illegal,
    output logic [2:0]       ex_alu_op,
    output logic             ex_alu_src_imm,
    output logic             ex_set_flags,
    output logic             mem_read_en,
    output logic             mem_write_en,
    output logic             wb_reg_write,
    output logic             wb_mem_to_reg,
    output logic [REG_W-1:0] wb_rd,
    output logic [3:0]       flags_q
);

    logic       run_d, run_q;
    logic       valid_id;
    logic       is_b, is_bl, is_bcond, is_cbz, is_br;
    logic       known;
    ctrl_word_t dec_w;
    logic [3:0] eff_flags;
    logic [3:0] flags_d;
    logic       cond_taken;

    logic       ex_valid_d, ex_valid_q;
    logic       mem_valid_d, mem_valid_q;
    logic       wb_valid_d, wb_valid_q;
    ctrl_word_t ex_d, ex_q;
    ctrl_word_t mem_d, mem_q;
    ctrl_word_t wb_d, wb_q;

    // Keeps ID quiet on the first cycle after reset release.
    assign run_d = 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) run_q <= 1'b0;
        else       run_q <= run_d;
    end

    assign valid_id = run_q & instr_valid & ~stall & ~flush;

    always_comb begin
        is_b     = 1'b0;
        is_bl    = 1'b0;
        is_bcond = 1'b0;
        is_cbz   = 1'b0;
        is_br    = 1'b0;
        known    = 1'b1;
        dec_w    = '0;
        dec_w.rd = instr[4:0];
        unique case (1'b1)
            instr[31:26] == OP_B:     is_b = 1'b1;
            instr[31:26] == OP_BL: begin
                is_bl           = 1'b1;
                dec_w.rd        = RD_W'(LINK_REG);
                dec_w.reg_write = 1'b1;
            end
            instr[31:24] == OP_BCOND: is_bcond = 1'b1;
            instr[31:24] == OP_CBZ:   is_cbz = 1'b1;
            instr[31:21] == OP_BR:    is_br = 1'b1;
            instr[31:21] == OP_ADDS: begin
                dec_w.alu_op    = ADD;
                dec_w.set_flags = 1'b1;
                dec_w.reg_write = 1'b1;
            end
            instr[31:21] == OP_SUBS: begin
                dec_w.alu_op    = SUB;
                dec_w.set_flags = 1'b1;
                dec_w.reg_write = 1'b1;
            end
            instr[31:22] == OP_ADDI: begin
                dec_w.alu_op      = ADD;
                dec_w.alu_src_imm = 1'b1;
                dec_w.reg_write   = 1'b1;
            end
            instr[31:21] == OP_LDUR: begin
                dec_w.alu_op      = ADD;
                dec_w.alu_src_imm = 1'b1;
                dec_w.mem_rd      = 1'b1;
                dec_w.reg_write   = 1'b1;
                dec_w.mem_to_reg  = 1'b1;
            end
            instr[31:21] == OP_STUR: begin
                dec_w.alu_op      = ADD;
                dec_w.alu_src_imm = 1'b1;
                dec_w.mem_wr      = 1'b1;
            end
            default: known = 1'b0;
        endcase
        if (is_xzr(dec_w.rd)) dec_w.reg_write = 1'b0;
    end

    // A flag-setting op still in EX overrides the architectural flags.
    assign eff_flags = (ex_valid_q & ex_q.set_flags)
                     ? {alu_n, alu_z, alu_c, alu_v}
                     : flags_q;

    cond_eval #(
        .FULL_COND(FULL_COND)
    ) u_cond (
        .cond (instr[3:0]),
        .nzcv (eff_flags),
        .taken(cond_taken)
    );

    assign br_uncond = valid_id & (is_b | is_bl);
    assign br_reg    = valid_id & is_br;
    assign illegal   = valid_id & ~known;
    assign br_taken  = valid_id & (is_b | is_bl | is_br
                     | (is_cbz & cbz_zero)
                     | (is_bcond & cond_taken));

    always_comb begin
        ex_valid_d  = valid_id & known;
        ex_d        = ex_valid_d ? dec_w : '0;
        mem_valid_d = ex_valid_q;
        mem_d       = ex_q;
        wb_valid_d  = mem_valid_q;
        wb_d        = mem_q;
        flags_d     = eff_flags;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_q       <= ex_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid_q <= 1'b0;
            mem_q       <= '0;
        end else begin
            mem_valid_q <= mem_valid_d;
            mem_q       <= mem_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            wb_q       <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_q       <= wb_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) flags_q <= 4'b0000;
        else       flags_q <= flags_d;
    end

    assign ex_alu_op      = ex_q.alu_op;
    assign ex_alu_src_imm = ex_q.alu_src_imm;
    assign ex_set_flags   = ex_q.set_flags;
    assign mem_read_en    = mem_q.mem_rd;
    assign mem_write_en   = mem_q.mem_wr;
    assign wb_reg_write   = wb_q.reg_write;
    assign wb_mem_to_reg  = wb_q.mem_to_reg;
    assign wb_rd          = REG_W'(wb_q.rd);

    logic unused_bits;
    assign unused_bits = ^{instr[20:5], wb_valid_q, wb_q.alu_op,
                           wb_q.alu_src_imm, wb_q.set_flags,
                           wb_q.mem_rd, wb_q.mem_wr};

endmodule
